cascade_mod_counter: RTL and testbench

//  Two-stage cascaded modulo counter: the inner stage counts enabled cycles; each inner wrap advances the outer stage.

---
 rtl/cascade_mod_counter_pkg.sv | 18 +
 rtl/mod_counter_stage.sv | 65 ++++++
 rtl/cascade_mod_counter.sv | 100 ++++++++++
 tb/tb_cascade_mod_counter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/cascade_mod_counter_pkg.sv
// Shared widths and modulus helper for the cascaded modulo counter.
// Latency: none (package only).
// Backpressure: none (package only).
package cascade_mod_counter_pkg;

    localparam int IW_DEF = 4;
    localparam int OW_DEF = 4;

    // A programmed modulus of 0 stands for the full 2^w range. The result is
    // 32 bits wide so that 2^w can be represented for any stage width below 32.
    function automatic logic [31:0] eff_mod(input logic [31:0] mod, input int unsigned w);
        if (mod == 32'd0) begin
            return 32'd1 << w;
        end
        return mod;
    endfunction

endpackage

// File: rtl/mod_counter_stage.sv
// One programmable modulo stage: counts on step and wraps when count >= mod-1.
// Latency: count/wrap registered (visible 1 cycle after the edge); carry is combinational.
// Backpressure: none; step is taken unconditionally when no clear or load is pending.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   step            advance this cycle
//   clr             synchronous clear of count and wrap (beats ld and step)
//   mod             modulus, 0 means 2^W
//   ld, ld_val      synchronous load of the count (beats step)
//   cnt             current count
//   carry           combinational: this step wraps the stage
//   wrap            registered pulse: the stage wrapped on the previous edge
module mod_counter_stage
    import cascade_mod_counter_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         step,
    input  logic         clr,
    input  logic [W-1:0] mod,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    output logic [W-1:0] cnt,
    output logic         carry,
    output logic         wrap
);

    logic [W-1:0] r_cnt;
    logic         r_wrap;
    logic [31:0]  w_lim;

    // Terminal count. Compared with >= so a modulus lowered below the current
    // count (or a loaded value past it) wraps on the next step rather than
    // running on to the top of the range.
    assign w_lim = eff_mod(32'(mod), W) - 32'd1;
    assign carry = step & (32'(r_cnt) >= w_lim);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else if (clr) begin
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else if (ld) begin
            r_cnt  <= ld_val;
            r_wrap <= 1'b0;
        end else if (carry) begin
            r_cnt  <= '0;
            r_wrap <= 1'b1;
        end else if (step) begin
            r_cnt  <= r_cnt + 1'b1;
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign cnt  = r_cnt;
    assign wrap = r_wrap;

endmodule

// File: rtl/cascade_mod_counter.sv
// Two-stage cascaded modulo counter (inner ticks, outer advances on inner wrap) with one-shot stop.
// Latency: counts, wrap pulses and done are registered, visible 1 cycle after the sampling edge.
// Backpressure: none; en is ignored while done is set.
//
// Optional feature macro: CASCADE_MOD_COUNTER_LOAD_EN adds load/load_inner/load_outer.
// Ports:
//   clk, rst                clock, synchronous active-high reset
//   en                      advance the inner stage
//   clr                     clear counts, wraps and done
//   oneshot                 stop after the first outer wrap
//   inner_mod, outer_mod    moduli (0 means full range), sampled every cycle
//   inner_cnt, outer_cnt    counts
//   inner_wrap, outer_wrap  1-cycle wrap pulses
//   done                    sticky one-shot completion
//   load, load_inner, load_outer  (macro only) write both counts, clear done
module cascade_mod_counter
    import cascade_mod_counter_pkg::*;
#(
    parameter int IW = IW_DEF,
    parameter int OW = OW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    input  logic          oneshot,
    input  logic [IW-1:0] inner_mod,
    input  logic [OW-1:0] outer_mod,
`ifdef CASCADE_MOD_COUNTER_LOAD_EN
    input  logic          load,
    input  logic [IW-1:0] load_inner,
    input  logic [OW-1:0] load_outer,
`endif
    output logic [IW-1:0] inner_cnt,
    output logic [OW-1:0] outer_cnt,
    output logic          inner_wrap,
    output logic          outer_wrap,
    output logic          done
);

    logic          r_done;
    logic          w_ld;
    logic [IW-1:0] w_ld_inner;
    logic [OW-1:0] w_ld_outer;
    logic          w_inner_step;
    logic          w_inner_carry;
    logic          w_outer_carry;

`ifdef CASCADE_MOD_COUNTER_LOAD_EN
    assign w_ld       = load;
    assign w_ld_inner = load_inner;
    assign w_ld_outer = load_outer;
`else
    assign w_ld       = 1'b0;
    assign w_ld_inner = '0;
    assign w_ld_outer = '0;
`endif

    // Once the one-shot has completed the counter is frozen at 0/0.
    assign w_inner_step = en & ~r_done;

    mod_counter_stage #(.W(IW)) u_inner (
        .clk    (clk),
        .rst    (rst),
        .step   (w_inner_step),
        .clr    (clr),
        .mod    (inner_mod),
        .ld     (w_ld),
        .ld_val (w_ld_inner),
        .cnt    (inner_cnt),
        .carry  (w_inner_carry),
        .wrap   (inner_wrap)
    );

    mod_counter_stage #(.W(OW)) u_outer (
        .clk    (clk),
        .rst    (rst),
        .step   (w_inner_carry),
        .clr    (clr),
        .mod    (outer_mod),
        .ld     (w_ld),
        .ld_val (w_ld_outer),
        .cnt    (outer_cnt),
        .carry  (w_outer_carry),
        .wrap   (outer_wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_done <= 1'b0;
        end else if (clr || w_ld) begin
            r_done <= 1'b0;
        end else if (oneshot && w_outer_carry) begin
            r_done <= 1'b1;
        end
    end

    assign done = r_done;

endmodule

// File: tb/tb_cascade_mod_counter.sv
module tb_cascade_mod_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic       clr;
    logic       oneshot;
    logic [3:0] inner_mod;
    logic [3:0] outer_mod;
`ifdef CASCADE_MOD_COUNTER_LOAD_EN
    logic       load;
    logic [3:0] load_inner;
    logic [3:0] load_outer;
`endif
    logic [3:0] inner_cnt;
    logic [3:0] outer_cnt;
    logic       inner_wrap;
    logic       outer_wrap;
    logic       done;

    int n_tests;
    int n_fail;

    cascade_mod_counter #(.IW(4), .OW(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .clr        (clr),
        .oneshot    (oneshot),
        .inner_mod  (inner_mod),
        .outer_mod  (outer_mod),
`ifdef CASCADE_MOD_COUNTER_LOAD_EN
        .load       (load),
        .load_inner (load_inner),
        .load_outer (load_outer),
`endif
        .inner_cnt  (inner_cnt),
        .outer_cnt  (outer_cnt),
        .inner_wrap (inner_wrap),
        .outer_wrap (outer_wrap),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag, input int ic, input int oc,
                             input int iw, input int ow, input int dn);
        check({tag, "_inner"}, 32'(inner_cnt), 32'(ic));
        check({tag, "_outer"}, 32'(outer_cnt), 32'(oc));
        check({tag, "_iwrap"}, 32'(inner_wrap), 32'(iw));
        check({tag, "_owrap"}, 32'(outer_wrap), 32'(ow));
        check({tag, "_done"},  32'(done),       32'(dn));
    endtask

    int exp_in  [12] = '{1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0};
    int exp_out [12] = '{0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 0};
    int exp_iw  [12] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1};
    int exp_ow  [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1; en = 1'b1; clr = 1'b0; oneshot = 1'b0;
        inner_mod = 4'd4; outer_mod = 4'd3;
`ifdef CASCADE_MOD_COUNTER_LOAD_EN
        load = 1'b0; load_inner = 4'd0; load_outer = 4'd0;
`endif
        #2;
        tick();
        tick();
        check_all("reset", 0, 0, 0, 0, 0);
        rst = 1'b0;

        // 1: mods 4/3 free-running from reset
        for (int k = 0; k < 12; k++) begin
            tick();
            check_all($sformatf("t1_e%0d", k + 1), exp_in[k], exp_out[k], exp_iw[k], exp_ow[k], 0);
        end

        // 2: one-shot stops at the first outer wrap
        clr = 1'b1; tick(); clr = 1'b0;
        check_all("t2_clr", 0, 0, 0, 0, 0);
        oneshot = 1'b1;
        for (int k = 0; k < 11; k++) tick();
        check_all("t2_e11", 3, 2, 0, 0, 0);
        tick();
        check_all("t2_e12", 0, 0, 1, 1, 1);
        for (int k = 0; k < 10; k++) begin
            if (k == 5) oneshot = 1'b0;
            tick();
        end
        check_all("t2_hold", 0, 0, 0, 0, 1);
        clr = 1'b1; tick(); clr = 1'b0;
        check_all("t2_clr2", 0, 0, 0, 0, 0);
        tick();
        check_all("t2_resume", 1, 0, 0, 0, 0);

        // 5: clr beats en; en=0 freezes counts and drops wrap flags
        clr = 1'b1; tick(); clr = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        check_all("t5_pre", 2, 1, 0, 0, 0);
        clr = 1'b1; tick(); clr = 1'b0;
        check_all("t5_clr_en", 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) tick();
        check_all("t5_wrap", 0, 1, 1, 0, 0);
        en = 1'b0;
        tick();
        check_all("t5_idle1", 0, 1, 0, 0, 0);
        for (int k = 0; k < 4; k++) tick();
        check_all("t5_idle5", 0, 1, 0, 0, 0);
        en = 1'b1;

        // 4: modulus lowered below the current count wraps on the next step
        clr = 1'b1; tick(); clr = 1'b0;
        inner_mod = 4'd8;
        for (int k = 0; k < 6; k++) tick();
        check_all("t4_six", 6, 0, 0, 0, 0);
        inner_mod = 4'd3;
        tick();
        check_all("t4_lower", 0, 1, 1, 0, 0);

        // 3: modulus 0 means full 16-count range on both stages
        clr = 1'b1; tick(); clr = 1'b0;
        inner_mod = 4'd0; outer_mod = 4'd0;
        for (int k = 0; k < 15; k++) tick();
        check_all("t3_e15", 15, 0, 0, 0, 0);
        tick();
        check_all("t3_e16", 0, 1, 1, 0, 0);
        for (int k = 0; k < 239; k++) tick();
        check_all("t3_e255", 15, 15, 0, 0, 0);
        tick();
        check_all("t3_e256", 0, 0, 1, 1, 0);

        // modulus 1 inner: stays 0 and carries every step; outer mod 2
        clr = 1'b1; tick(); clr = 1'b0;
        inner_mod = 4'd1; outer_mod = 4'd2;
        tick();
        check_all("m1_e1", 0, 1, 1, 0, 0);
        tick();
        check_all("m1_e2", 0, 0, 1, 1, 0);

`ifdef CASCADE_MOD_COUNTER_LOAD_EN
        // 6: loaded values at/above the limit wrap on the next step
        clr = 1'b1; tick(); clr = 1'b0;
        inner_mod = 4'd6; outer_mod = 4'd3;
        load = 1'b1; load_inner = 4'd5; load_outer = 4'd2;
        tick();
        load = 1'b0;
        check_all("t6_load", 5, 2, 0, 0, 0);
        tick();
        check_all("t6_wrap", 0, 0, 1, 1, 0);
`endif

        // synchronous reset mid-count overrides en
        clr = 1'b1; tick(); clr = 1'b0;
        inner_mod = 4'd5; outer_mod = 4'd4;
        for (int k = 0; k < 7; k++) tick();
        check_all("rst_pre", 2, 1, 0, 0, 0);
        rst = 1'b1;
        tick();
        check_all("rst_mid", 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick();
        check_all("rst_after", 1, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
